// File: rtl/instr_mem_loader.sv
// Boot loader: assembles big-endian 32-bit words from a byte stream and writes them
// to instruction memory from word address 0, holding the pipeline until the load ends.
module instr_mem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  PC_reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  pipe_hold,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_words_left;
    logic [31:0]           r_shift;
    logic [1:0]            r_byte_cnt;
    logic                  w_handshake;
    logic                  w_last_byte;
    logic                  w_last_word;

    assign w_handshake = byte_valid & byte_ready;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_last_word = (r_words_left == COUNT_ONE);

    always_ff @(posedge clk or posedge PC_reset) begin
        if (PC_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        imem_we      = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (word_count == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                byte_ready = 1'b1;
                if (w_handshake && w_last_byte) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                imem_we      = 1'b1;
                w_state_next = w_last_word ? S_DONE : S_RECV;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: the shift register doubles as the write-data register, so the
    // word is already aligned when WRITE presents it.
    always_ff @(posedge clk or posedge PC_reset) begin
        if (PC_reset) begin
            r_addr       <= '0;
            r_words_left <= '0;
            r_shift      <= '0;
            r_byte_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_words_left <= word_count;
                        r_addr       <= '0;
                        r_shift      <= '0;
                        r_byte_cnt   <= '0;
                    end
                end
                S_RECV: begin
                    if (w_handshake) begin
                        r_shift    <= {r_shift[23:0], byte_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_addr       <= r_addr + ADDR_ONE;
                    r_words_left <= r_words_left - COUNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr  = r_addr;
    assign imem_wdata = r_shift;
    assign busy       = (r_state != S_IDLE);
    assign pipe_hold  = (r_state != S_IDLE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader; expected words and cycle positions come
// from the byte stream and the load-timing rules, not from the design.
module tb_instr_mem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          PC_reset;
    logic          start;
    logic [AW:0]   word_count;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          pipe_hold;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] stim_bytes[$];

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .PC_reset   (PC_reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .pipe_hold  (pipe_hold),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are Moore; sampling 1 ns after an edge gives the values the next edge sees.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        stim_bytes.delete();
        for (int i = 0; i < n; i++) begin
            stim_bytes.push_back(8'($urandom));
        end
    endtask

    // mode 0: byte_valid held high, 1: valid on odd cycles, 2: random gaps.
    task automatic run_load(input string name, input int n_words, input int mode, input int glitch_c);
        int          wr_cyc[$];
        logic [AW-1:0] wr_addr[$];
        logic [31:0] wr_data[$];
        int          hs_cyc[$];
        int          idx, c, limit, n_bytes;
        int          done_cnt, done_c, pipe_low_c, exp_done, exp_wc;
        int          early_drop, busy_mismatch;
        logic        v;
        logic [31:0] exp_word;

        n_bytes       = n_words * 4;
        limit         = 5 * n_words + 40 + ((mode != 0) ? 8 * n_bytes : 0);
        idx           = 0;
        done_cnt      = 0;
        done_c        = -1;
        pipe_low_c    = -1;
        early_drop    = 0;
        busy_mismatch = 0;

        start      = 1'b1;
        word_count = (AW+1)'(n_words);
        byte_valid = 1'b0;
        tick();
        start      = 1'b0;
        word_count = (AW+1)'($urandom);

        c = 1;
        while (pipe_low_c < 0 && c < limit) begin
            if (imem_we) begin
                wr_cyc.push_back(c);
                wr_addr.push_back(imem_addr);
                wr_data.push_back(imem_wdata);
            end
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            if (busy !== pipe_hold) busy_mismatch++;
            if (!pipe_hold) begin
                pipe_low_c = c;
                if (done_cnt == 0) early_drop = 1;
            end else begin
                if (c == glitch_c) begin
                    start      = 1'b1;
                    word_count = (AW+1)'(3);
                end else begin
                    start = 1'b0;
                end
                case (mode)
                    0:       v = (idx < n_bytes);
                    1:       v = (c % 2 == 1) && (idx < n_bytes);
                    default: v = ($urandom_range(0, 2) != 0) && (idx < n_bytes);
                endcase
                byte_valid = v;
                byte_data  = v ? stim_bytes[idx] : 8'($urandom);
                if (v && byte_ready) begin
                    hs_cyc.push_back(c);
                    idx++;
                end
                tick();
                c++;
            end
        end
        start      = 1'b0;
        byte_valid = 1'b0;

        check_eq({name, " completed"}, 64'(pipe_low_c >= 0), 64'd1);
        check_eq({name, " handshakes"}, 64'(hs_cyc.size()), 64'(n_bytes));
        check_eq({name, " write count"}, 64'(wr_cyc.size()), 64'(n_words));
        for (int k = 0; k < n_words && k < wr_cyc.size(); k++) begin
            exp_word = {stim_bytes[4*k], stim_bytes[4*k+1], stim_bytes[4*k+2], stim_bytes[4*k+3]};
            if (mode == 0) exp_wc = 5 * k + 5;
            else if (hs_cyc.size() > 4 * k + 3) exp_wc = hs_cyc[4*k+3] + 1;
            else exp_wc = -1;
            check_eq({name, " write addr"}, 64'(wr_addr[k]), 64'(k % (1 << AW)));
            check_eq({name, " write data"}, 64'(wr_data[k]), 64'(exp_word));
            check_eq({name, " write cycle"}, 64'(wr_cyc[k]), 64'(exp_wc));
        end
        if (n_words == 0) exp_done = 1;
        else if (mode == 0) exp_done = 5 * n_words + 1;
        else if (hs_cyc.size() >= n_bytes) exp_done = hs_cyc[n_bytes-1] + 2;
        else exp_done = -1;
        check_eq({name, " done pulses"}, 64'(done_cnt), 64'd1);
        check_eq({name, " done cycle"}, 64'(done_c), 64'(exp_done));
        check_eq({name, " hold release cycle"}, 64'(pipe_low_c), 64'(exp_done + 1));
        check_eq({name, " hold dropped early"}, 64'(early_drop), 64'd0);
        check_eq({name, " busy vs pipe_hold"}, 64'(busy_mismatch), 64'd0);
        $display("load %s: words=%0d mode=%0d writes=%0d handshakes=%0d done@%0d hold_low@%0d",
                 name, n_words, mode, wr_cyc.size(), hs_cyc.size(), done_c, pipe_low_c);
    endtask

    initial begin
        int n;

        // Reset with random inputs applied
        PC_reset   = 1'b1;
        start      = 1'($urandom);
        word_count = (AW+1)'($urandom);
        byte_valid = 1'($urandom);
        byte_data  = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("reset byte_ready", 64'(byte_ready), 64'd0);
            check_eq("reset imem_we", 64'(imem_we), 64'd0);
            check_eq("reset imem_addr", 64'(imem_addr), 64'd0);
            check_eq("reset imem_wdata", 64'(imem_wdata), 64'd0);
            check_eq("reset busy/hold/done", 64'({busy, pipe_hold, done}), 64'd0);
            start      = 1'($urandom);
            byte_valid = 1'($urandom);
        end
        PC_reset   = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("idle byte_ready", 64'(byte_ready), 64'd0);
            check_eq("idle busy", 64'(busy), 64'd0);
        end
        byte_valid = 1'b0;
        $display("reset sequence complete");

        stim_bytes = {8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        run_load("two_word", 2, 0, -1);
        run_load("throttled", 2, 1, -1);

        stim_bytes.delete();
        run_load("zero_length", 0, 0, -1);

        // Reset after two bytes of the first word
        start      = 1'b1;
        word_count = (AW+1)'(2);
        tick();
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        tick();
        check_eq("midword no write 1", 64'(imem_we), 64'd0);
        byte_data = 8'hBB;
        tick();
        check_eq("midword no write 2", 64'(imem_we), 64'd0);
        PC_reset = 1'b1;
        #1;
        check_eq("midword reset busy", 64'(busy), 64'd0);
        check_eq("midword reset imem_we", 64'(imem_we), 64'd0);
        check_eq("midword reset wdata", 64'(imem_wdata), 64'd0);
        byte_valid = 1'b0;
        tick();
        PC_reset = 1'b0;
        tick();
        $display("reset mid-word applied");
        stim_bytes = {8'h11, 8'h22, 8'h33, 8'h44};
        run_load("restart", 1, 0, -1);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            fill_random(4 * n);
            run_load("random_gaps", n, 2, -1);
        end

        fill_random(4 * (1 << AW));
        run_load("full_memory", 1 << AW, 0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
